// File: rtl/iob_reset_sequencer.sv
// Power-on / reset sequencer for FPGA top-level wrappers.
// Stretches reset across N_CH clock-enabled domains. It waits for memory-controller
// calibration, then releases the channels one at a time, starting with channel 0.
// A calibration timeout triggers a retry. Calibration loss or a start request in DONE
// re-runs the sequence.
module iob_reset_sequencer #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned START         = 5,
  parameter int unsigned DURATION      = 10,
  parameter int unsigned STAGE_GAP     = 4,
  parameter int unsigned CALIB_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cke_i,
  input  logic            start_i,
  input  logic            calib_done_i,
  output logic [N_CH-1:0] rst_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            timeout_o,
  output logic [7:0]      retry_cnt_o
);

  localparam int unsigned IdxW = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Counters load "duration - 1" and the state moves on the edge that sees zero, so a
  // state lasts exactly its nominal number of enabled edges.
  localparam logic [CNT_W-1:0] StartLoad = CNT_W'(START - 1);
  localparam logic [CNT_W-1:0] DurLoad   = CNT_W'(DURATION - 1);
  localparam logic [CNT_W-1:0] GapLoad   = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CalLoad   = CNT_W'(CALIB_TIMEOUT - 1);
  localparam logic [IdxW-1:0]  LastIdx   = IdxW'(N_CH - 1);

  typedef enum logic [2:0] {
    StInit,
    StWaitStart,
    StAssert,
    StWaitCalib,
    StRelease,
    StDone
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IdxW-1:0]   idx_q;     // next channel to release while in StRelease
  logic [N_CH-1:0]   rst_q;
  logic              busy_q;
  logic              done_q;
  logic              timeout_q;
  logic [7:0]        retry_q;

  // Sequencer FSM with registered outputs; cke_i low freezes everything except rst_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_q     <= '1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      retry_q   <= 8'd0;
    end else if (cke_i) begin
      unique case (state_q)
        StInit: begin
          state_q <= StWaitStart;
          cnt_q   <= StartLoad;
        end

        StWaitStart: begin
          if (cnt_q == '0) begin
            state_q <= StAssert;
            cnt_q   <= DurLoad;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        StAssert: begin
          if (cnt_q == '0) begin
            state_q <= StWaitCalib;
            cnt_q   <= CalLoad;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        StWaitCalib: begin
          // Calibration seen on the final timeout edge still counts as success.
          if (calib_done_i) begin
            rst_q[0] <= 1'b0;
            if (N_CH == 1) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRelease;
              cnt_q   <= GapLoad;
              idx_q   <= IdxW'(1);
            end
          end else if (cnt_q == '0) begin
            timeout_q <= 1'b1;
            if (retry_q != 8'hFF) begin
              retry_q <= retry_q + 8'd1;
            end
            state_q <= StAssert;
            cnt_q   <= DurLoad;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        // calib_done_i is deliberately ignored here: once release starts it runs to DONE.
        StRelease: begin
          if (cnt_q == '0) begin
            rst_q[idx_q] <= 1'b0;
            if (idx_q == LastIdx) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IdxW'(1);
              cnt_q <= GapLoad;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        StDone: begin
          // Calibration loss takes priority over a simultaneous start request.
          if (!calib_done_i) begin
            state_q <= StAssert;
            cnt_q   <= DurLoad;
            rst_q   <= '1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else if (start_i) begin
            state_q <= StWaitStart;
            cnt_q   <= StartLoad;
            rst_q   <= '1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= StInit;
        end
      endcase
    end
  end

  assign rst_o       = rst_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_iob_reset_sequencer.sv
// Self-checking bench for iob_reset_sequencer: directed scenarios plus a randomized run,
// all compared against a timeline model kept in the bench.
module tb_iob_reset_sequencer;

  localparam int N_CH = 4;
  localparam int START = 5;
  localparam int DURATION = 10;
  localparam int GAP = 4;
  localparam int TO = 64;

  logic            clk;
  logic            rst_i;
  logic            cke_i;
  logic            start_i;
  logic            calib_done_i;
  logic [N_CH-1:0] rst_o;
  logic            busy_o;
  logic            done_o;
  logic            timeout_o;
  logic [7:0]      retry_cnt_o;

  int total = 0;
  int bad = 0;

  // Model: the timeline since the last origin edge (E0, start edge, timeout or calib loss).
  bit m_init;
  bit m_done;
  bit m_tmo;
  int m_retry;
  int m_k;    // enabled edges since origin
  int m_pre;  // edges before the calibration window opens
  int m_rel;  // edges since release entry, -1 if not yet released

  iob_reset_sequencer #(
    .N_CH(N_CH),
    .START(START),
    .DURATION(DURATION),
    .STAGE_GAP(GAP),
    .CALIB_TIMEOUT(TO),
    .CNT_W(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .cke_i(cke_i),
    .start_i(start_i),
    .calib_done_i(calib_done_i),
    .rst_o(rst_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .timeout_o(timeout_o),
    .retry_cnt_o(retry_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N_CH-1:0] m_rst_f();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = (m_rel < 0) ? 1'b1 : (m_rel < GAP * i);
    return v;
  endfunction

  function automatic logic [14:0] m_vec_f();
    return {m_rst_f(), !m_done, m_done, m_tmo, 8'(m_retry)};
  endfunction

  task automatic m_origin(input int pre);
    m_k = 0;
    m_pre = pre;
    m_rel = -1;
  endtask

  // Drive one cycle, update the model on the edge, settle before the caller samples.
  task automatic tick(input bit r, input bit c, input bit s, input bit cal);
    rst_i = r;
    cke_i = c;
    start_i = s;
    calib_done_i = cal;
    @(posedge clk);
    if (r) begin
      m_init = 1; m_done = 0; m_tmo = 0; m_retry = 0; m_rel = -1; m_k = 0;
    end else if (c) begin
      if (m_init) begin
        m_init = 0;
        m_origin(START + DURATION);
      end else if (m_done) begin
        if (!cal) begin
          m_done = 0;
          m_origin(DURATION);
        end else if (s) begin
          m_done = 0;
          m_origin(START + DURATION);
        end
      end else if (m_rel >= 0) begin
        m_rel++;
        if (m_rel >= GAP * (N_CH - 1)) m_done = 1;
      end else begin
        m_k++;
        if (m_k > m_pre) begin
          if (cal) begin
            m_rel = 0;
            if (GAP * (N_CH - 1) == 0) m_done = 1;
          end else if (m_k == m_pre + TO) begin
            m_tmo = 1;
            if (m_retry < 255) m_retry++;
            m_origin(DURATION);
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, 1);
      total++;
      if ({rst_o, busy_o, done_o, timeout_o, retry_cnt_o} !== {4'hF, 1'b1, 1'b0, 1'b0, 8'd0}) begin
        bad++;
        $display("FAIL reset_values: got rst=%h busy=%b done=%b tmo=%b retry=%0d want F/1/0/0/0",
                 rst_o, busy_o, done_o, timeout_o, retry_cnt_o);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] exp_r;
    for (int e = 0; e <= 35; e++) begin
      tick(0, 1, 0, 1);
      total++;
      if ({rst_o, busy_o, done_o, timeout_o, retry_cnt_o} !== m_vec_f()) begin
        bad++;
        $display("FAIL basic_model E%0d: got %h want %h", e,
                 {rst_o, busy_o, done_o, timeout_o, retry_cnt_o}, m_vec_f());
      end
      if (e == 15 || e == 16 || e == 19 || e == 20 || e == 24 || e == 27 || e == 28) begin
        exp_r = (e < 16) ? 4'hF : (e < 20) ? 4'hE : (e < 24) ? 4'hC : (e < 28) ? 4'h8 : 4'h0;
        total++;
        if (rst_o !== exp_r || done_o !== (e >= 28)) begin
          bad++;
          $display("FAIL basic_stage E%0d: got rst=%h done=%b want rst=%h done=%b",
                   e, rst_o, done_o, exp_r, (e >= 28));
        end
      end
    end
  endtask

  task automatic test_timeout();
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    for (int e = 0; e < 240; e++) begin
      tick(0, 1, 0, e >= 200);
      total++;
      if ({rst_o, busy_o, done_o, timeout_o, retry_cnt_o} !== m_vec_f()) begin
        bad++;
        $display("FAIL timeout_model E%0d: got %h want %h", e,
                 {rst_o, busy_o, done_o, timeout_o, retry_cnt_o}, m_vec_f());
      end
      if (e == 78 || e == 79) begin
        total++;
        if (timeout_o !== (e == 79) || retry_cnt_o !== ((e == 79) ? 8'd1 : 8'd0)) begin
          bad++;
          $display("FAIL timeout_first E%0d: got tmo=%b retry=%0d", e, timeout_o, retry_cnt_o);
        end
      end
      if (e == 199) begin
        total++;
        if (retry_cnt_o !== 8'd2 || done_o !== 1'b0 || busy_o !== 1'b1 || rst_o !== 4'hF) begin
          bad++;
          $display("FAIL timeout_waiting: got retry=%0d done=%b busy=%b rst=%h want 2/0/1/F",
                   retry_cnt_o, done_o, busy_o, rst_o);
        end
      end
    end
    total++;
    if (done_o !== 1'b1 || retry_cnt_o !== 8'd2 || timeout_o !== 1'b1 || rst_o !== 4'h0) begin
      bad++;
      $display("FAIL timeout_recover: got done=%b retry=%0d tmo=%b rst=%h want 1/2/1/0",
               done_o, retry_cnt_o, timeout_o, rst_o);
    end
  endtask

  task automatic test_start();
    tick(0, 1, 1, 1);
    total++;
    if (rst_o !== 4'hF || busy_o !== 1'b1 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL start_restart: got rst=%h busy=%b done=%b want F/1/0", rst_o, busy_o, done_o);
    end
    for (int j = 1; j <= 30; j++) begin
      tick(0, 1, 0, 1);
      total++;
      if ({rst_o, busy_o, done_o, timeout_o, retry_cnt_o} !== m_vec_f()) begin
        bad++;
        $display("FAIL start_model j%0d: got %h want %h", j,
                 {rst_o, busy_o, done_o, timeout_o, retry_cnt_o}, m_vec_f());
      end
      if (j == 15 || j == 16) begin
        total++;
        if (rst_o !== ((j == 15) ? 4'hF : 4'hE)) begin
          bad++;
          $display("FAIL start_spacing j%0d: got rst=%h", j, rst_o);
        end
      end
    end
  endtask

  task automatic test_calib_loss();
    tick(0, 1, 1, 0);
    total++;
    if (rst_o !== 4'hF || busy_o !== 1'b1 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL loss_restart: got rst=%h busy=%b done=%b want F/1/0", rst_o, busy_o, done_o);
    end
    for (int j = 1; j <= 25; j++) begin
      tick(0, 1, 0, 1);
      total++;
      if ({rst_o, busy_o, done_o, timeout_o, retry_cnt_o} !== m_vec_f()) begin
        bad++;
        $display("FAIL loss_model j%0d: got %h want %h", j,
                 {rst_o, busy_o, done_o, timeout_o, retry_cnt_o}, m_vec_f());
      end
      // Release after DURATION+1 edges proves the start request was not honoured.
      if (j == 10 || j == 11) begin
        total++;
        if (rst_o !== ((j == 10) ? 4'hF : 4'hE)) begin
          bad++;
          $display("FAIL loss_priority j%0d: got rst=%h", j, rst_o);
        end
      end
    end
  endtask

  task automatic test_cke();
    tick(1, 1, 0, 1);
    tick(1, 1, 0, 1);
    for (int w = 0; w <= 40; w++) begin
      tick(0, !(w >= 8 && w < 15), 0, 1);
      total++;
      if ({rst_o, busy_o, done_o, timeout_o, retry_cnt_o} !== m_vec_f()) begin
        bad++;
        $display("FAIL cke_model w%0d: got %h want %h", w,
                 {rst_o, busy_o, done_o, timeout_o, retry_cnt_o}, m_vec_f());
      end
      if (w == 22 || w == 23 || w == 34 || w == 35) begin
        total++;
        if (rst_o !== ((w == 22) ? 4'hF : (w == 23) ? 4'hE : (w == 34) ? 4'h8 : 4'h0)
            || done_o !== (w == 35)) begin
          bad++;
          $display("FAIL cke_shift w%0d: got rst=%h done=%b", w, rst_o, done_o);
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    int n;
    tick(1, 1, 0, 0);
    for (int e = 0; e < 85; e++) tick(0, 1, 0, 0);
    n = 0;
    while (m_rst_f() != 4'hC && n < 60) begin
      tick(0, 1, 0, 1);
      n++;
    end
    total++;
    if (n >= 60 || rst_o !== 4'hC || retry_cnt_o !== 8'd1) begin
      bad++;
      $display("FAIL rstmid_reach: got rst=%h retry=%0d after %0d cycles want C/1", rst_o,
               retry_cnt_o, n);
    end
    tick(1, 1, 0, 1);
    total++;
    if ({rst_o, busy_o, done_o, timeout_o, retry_cnt_o} !== {4'hF, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL rstmid_clear: got rst=%h busy=%b done=%b tmo=%b retry=%0d want F/1/0/0/0",
               rst_o, busy_o, done_o, timeout_o, retry_cnt_o);
    end
    for (int e = 0; e <= 16; e++) begin
      tick(0, 1, 0, 1);
      if (e == 15 || e == 16) begin
        total++;
        if (rst_o !== ((e == 15) ? 4'hF : 4'hE)) begin
          bad++;
          $display("FAIL rstmid_restart E%0d: got rst=%h", e, rst_o);
        end
      end
    end
  endtask

  task automatic test_random();
    bit cal;
    bit r;
    cal = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) cal = !cal;
      r = (i < 2) || ($urandom_range(0, 299) == 0);
      tick(r, $urandom_range(0, 99) < 85, $urandom_range(0, 19) == 0, cal);
      total++;
      if ({rst_o, busy_o, done_o, timeout_o, retry_cnt_o} !== m_vec_f()) begin
        bad++;
        $display("FAIL random_model i%0d: got %h want %h", i,
                 {rst_o, busy_o, done_o, timeout_o, retry_cnt_o}, m_vec_f());
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    cke_i = 1'b1;
    start_i = 1'b0;
    calib_done_i = 1'b1;
    m_init = 1; m_done = 0; m_tmo = 0; m_retry = 0; m_rel = -1; m_k = 0; m_pre = 0;
    test_reset();
    test_basic();
    test_timeout();
    test_start();
    test_calib_loss();
    test_cke();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
